// File: rtl/sdpram_pkg.sv
// Shared defaults and word/address types for the simple dual-port RAM.
// Imported by the interface, the storage array and the top.
package sdpram_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_OUT_REG = 0;
    localparam int DEF_ADDR_W  = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;

endpackage : sdpram_pkg

// File: rtl/sdpram_if.sv
// Port bundle for the simple dual-port RAM.
// sdp_s is the RAM side; sdp_m is the driving side.
interface sdpram_if
    import sdpram_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int OUT_REG = DEF_OUT_REG
) ();

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              wena;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              renb;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic              validb;

    modport sdp_s (
        input  wena, addra, dina, renb, addrb,
        output doutb, validb
    );

    modport sdp_m (
        output wena, addra, dina, renb, addrb,
        input  doutb, validb
    );

endinterface : sdpram_if

// File: rtl/sdpram_array.sv
// Storage array with one write port and one registered, read-first read port.
// Out-of-range addresses (non-power-of-2 depth) drop writes and read back zero.
module sdpram_array
    import sdpram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;
    logic              wr_ok_s;
    logic              rd_ok_s;

    // A full power-of-2 array has no unreachable addresses, so skip the compare
    if (DEPTH == (32'd1 << ADDR_W)) begin : g_pow2
        assign wr_ok_s = 1'b1;
        assign rd_ok_s = 1'b1;
    end else begin : g_npow2
        assign wr_ok_s = (int'(waddr) < DEPTH);
        assign rd_ok_s = (int'(raddr) < DEPTH);
    end

    // Write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we && wr_ok_s) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; sees the pre-write word on an address collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= rd_ok_s ? mem_r[raddr] : '0;
        end
    end

    assign rdata = rdata_r;

endmodule : sdpram_array

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port synchronous RAM: write-only port A, read-only port B, one clock.
// Adds control gating, the optional output register and the validb pipe around the array.
module simple_dual_port_ram
    import sdpram_pkg::*;
(
    input logic     clk,
    input logic     rst,
    sdpram_if.sdp_s ifp
);

    localparam int DATA_W  = ifp.DATA_W;
    localparam int DEPTH   = ifp.DEPTH;
    localparam int OUT_REG = ifp.OUT_REG;
    localparam int ADDR_W  = ifp.ADDR_W;

    logic              we_s;
    logic              re_s;
    logic [DATA_W-1:0] rdata_s;
    logic              rd_valid_r;

    // Masking with rst keeps undriven controls from reaching the array during reset
    always_comb begin
        we_s = ifp.wena & rst;
        re_s = ifp.renb & rst;
    end

    sdpram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst),
        .we    (we_s),
        .waddr (ifp.addra),
        .wdata (ifp.dina),
        .re    (re_s),
        .raddr (ifp.addrb),
        .rdata (rdata_s)
    );

    // Marks a word freshly loaded into the array read register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= re_s;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] dout_r;
        logic              valid_r;

        // Extra output stage; only captures on a completed read so doutb holds otherwise
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_r  <= '0;
                valid_r <= 1'b0;
            end else begin
                valid_r <= rd_valid_r;
                if (rd_valid_r) begin
                    dout_r <= rdata_s;
                end
            end
        end

        assign ifp.doutb  = dout_r;
        assign ifp.validb = valid_r;
    end else begin : g_no_out_reg
        assign ifp.doutb  = rdata_s;
        assign ifp.validb = rd_valid_r;
    end

endmodule : simple_dual_port_ram

// File: tb/tb_simple_dual_port_ram.sv
// Directed bench for simple_dual_port_ram with a reference memory and a queue of
// expected read words, compared at the cycle each word is due on doutb.
module tb_simple_dual_port_ram;
    import sdpram_pkg::*;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 1024;
    localparam int OUT_REG = 0;
    localparam int LAT     = OUT_REG + 1;

    typedef struct {
        int    due;
        data_t data;
        bit    known;
    } exp_t;

    logic  clk;
    logic  rst;
    exp_t  exp_q [$];
    data_t model_mem   [DEPTH];
    bit    model_known [DEPTH];
    data_t model_dout;
    bit    model_dout_known;
    int    cyc;
    int    checks;
    int    errors;

    sdpram_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_REG(OUT_REG)) ifp ();

    simple_dual_port_ram dut (
        .clk (clk),
        .rst (rst),
        .ifp (ifp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare validb and doutb against the model for the current cycle
    task automatic check_outputs(input string tag);
        bit   exp_v;
        exp_t e;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        checks++;
        assert (ifp.validb === exp_v) else begin
            errors++;
            $error("FAIL %s validb cyc %0d got %b exp %b", tag, cyc, ifp.validb, exp_v);
        end
        if (exp_v) begin
            e = exp_q.pop_front();
            model_dout       = e.data;
            model_dout_known = e.known;
        end
        if (model_dout_known) begin
            checks++;
            assert (ifp.doutb === model_dout) else begin
                errors++;
                $error("FAIL %s doutb cyc %0d got %h exp %h", tag, cyc, ifp.doutb, model_dout);
            end
        end
    endtask

    // One clock edge: update the model (read before write), then sample 1 time unit later
    task automatic tick(input string tag);
        @(posedge clk);
        cyc++;
        if (rst && ifp.renb) begin
            exp_q.push_back('{cyc + LAT - 1, model_mem[ifp.addrb], model_known[ifp.addrb]});
        end
        if (rst && ifp.wena) begin
            model_mem[ifp.addra]   = ifp.dina;
            model_known[ifp.addra] = 1'b1;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        model_dout       = '0;
        model_dout_known = 1'b1;
        ifp.wena  = 1'b0;
        ifp.addra = '0;
        ifp.dina  = '0;
        ifp.renb  = 1'b0;
        ifp.addrb = '0;

        // Power-on reset
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_outputs("reset_init");
        tick("in_reset");
        tick("in_reset");
        rst = 1'b1;
        tick("post_reset");

        // Collision on address 1: old word first, new word from the next edge
        ifp.wena  = 1'b1;
        ifp.addra = 10'd1;
        ifp.dina  = 32'h0000_0055;
        ifp.renb  = 1'b1;
        ifp.addrb = 10'd1;
        tick("collide_e1");
        ifp.wena = 1'b0;
        tick("collide_e2");
        tick("collide_e3");

        // Hold: doutb keeps 0x55 with validb low
        ifp.renb = 1'b0;
        tick("hold");
        tick("hold");

        // Write attempt with wena low must not disturb address 1
        ifp.addra = 10'd1;
        ifp.dina  = 32'h0000_00FF;
        tick("wena0");
        ifp.renb  = 1'b1;
        ifp.addrb = 10'd1;
        tick("wena0_rd");
        ifp.renb = 1'b0;
        for (int i = 0; i < LAT; i++) tick("wena0_drain");

        // Top address write then read
        ifp.wena  = 1'b1;
        ifp.addra = 10'h3FF;
        ifp.dina  = 32'hDEAD_BEEF;
        tick("top_wr");
        ifp.wena = 1'b0;
        tick("idle");
        ifp.renb  = 1'b1;
        ifp.addrb = 10'h3FF;
        tick("top_rd");
        ifp.renb = 1'b0;
        for (int i = 0; i < LAT; i++) tick("top_drain");

        // Back-to-back writes k*3 then streamed reads
        for (int k = 0; k < 16; k++) begin
            ifp.wena  = 1'b1;
            ifp.addra = addr_t'(k);
            ifp.dina  = data_t'(k * 3);
            tick("b2b_wr");
        end
        ifp.wena = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ifp.renb  = 1'b1;
            ifp.addrb = addr_t'(k);
            tick("b2b_rd");
        end
        ifp.renb = 1'b0;
        for (int i = 0; i < LAT; i++) tick("b2b_drain");

        // Reset mid-stream: outputs clear without a clock, writes ignored
        ifp.renb  = 1'b1;
        ifp.addrb = 10'd2;
        tick("pre_rst_rd");
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        model_dout       = '0;
        model_dout_known = 1'b1;
        check_outputs("async_rst");
        ifp.wena  = 1'b1;
        ifp.addra = 10'd5;
        ifp.dina  = 32'h0000_00AA;
        tick("rst_wr");
        tick("rst_wr");
        rst       = 1'b1;
        ifp.wena  = 1'b0;
        ifp.addrb = 10'd5;
        tick("post_rst_rd5");
        ifp.addrb = 10'd1;
        tick("post_rst_rd1");
        ifp.renb = 1'b0;
        for (int i = 0; i < LAT; i++) tick("rst_drain");

        // Mixed random traffic over the initialised low addresses
        for (int i = 0; i < 40; i++) begin
            ifp.wena  = 1'($urandom_range(0, 1));
            ifp.addra = addr_t'($urandom_range(0, 15));
            ifp.dina  = data_t'($urandom);
            ifp.renb  = 1'($urandom_range(0, 1));
            ifp.addrb = addr_t'($urandom_range(0, 15));
            tick("rand");
        end
        ifp.wena = 1'b0;
        ifp.renb = 1'b0;
        for (int i = 0; i < LAT + 1; i++) tick("rand_drain");

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain_empty pending %0d exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_simple_dual_port_ram
